servo_pulse_decoder: RTL

Receive-side counterpart to the servo output pin: measures the high time of an incoming RC-servo PWM pulse train (1–2 ms pulse, ~20 ms frame) and converts it to a position code. Sits between an FPGA input pad (servo/RC receiver signal) and the control logic. It also drives status LEDs and flags out-of-range pulses and loss of signal. Runs in the 25 MHz board clock domain.

---
 rtl/servo_pkg.sv | 37 +++
 rtl/sync_edge.sv | 38 +++
 rtl/servo_pulse_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// ============================================================
// servo_pkg: shared types and helpers for the servo pulse decoder
// Rev 1.0
// ============================================================
`default_nettype none

package servo_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } state_t;

  typedef logic [15:0] width_t;

  localparam int unsigned DEF_CLK_HZ = 25_000_000;
  localparam int unsigned US_DIV     = DEF_CLK_HZ / 1_000_000;

  function automatic int unsigned us_div(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Fixed-point gain mapping (width - min) onto 0..2^pos_w-1, rounded to nearest.
  function automatic longint unsigned calc_scale(input int unsigned min_us,
                                                 input int unsigned max_us,
                                                 input int unsigned pos_w);
    longint unsigned span;
    longint unsigned num;
    span = 64'(max_us - min_us);
    num  = (64'd1 << 16) * ((64'd1 << pos_w) - 64'd1);
    return (num + span / 64'd2) / span;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================
// sync_edge: multi-flop synchronizer with rise/fall detect
// Rev 1.0
// ============================================================
`default_nettype none

module sync_edge #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

`default_nettype wire

// File: rtl/servo_pulse_decoder.sv
// ============================================================
// servo_pulse_decoder: measures RC-servo pulse width, emits position code
// Rev 1.0
// ============================================================
`default_nettype none

module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25_000_000,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned MAX_US      = 2000,
  parameter int unsigned TIMEOUT_US  = 25000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned POS_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [15:0]      width_us,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             err_range,
  output logic             signal_lost,
  output logic             led_verde,
  output logic             led_verm
);

  localparam int unsigned CYC_PER_US = us_div(CLK_HZ);
  localparam int unsigned PW         = $clog2(CYC_PER_US + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_US - 1);
  localparam width_t      TIMEOUT    = width_t'(TIMEOUT_US);
  localparam width_t      MIN_W      = width_t'(MIN_US);
  localparam width_t      MAX_W      = width_t'(MAX_US);
  localparam logic [31:0] SCALE      = 32'(calc_scale(MIN_US, MAX_US, POS_W));
  localparam logic [31:0] POS_MAX    = 32'((64'd1 << POS_W) - 64'd1);

  logic pin_level, pin_rise, pin_fall;

  // Idle-high reset level keeps a pulse already present at reset release from
  // looking like a fresh rising edge.
  sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pulse_in),
    .level (pin_level),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  logic [PW-1:0] presc_q;
  logic          us_tick;

  assign us_tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     presc_q <= '0;
    else if (pin_rise || us_tick) presc_q <= '0;
    else                         presc_q <= presc_q + PW'(1);
  end

  state_t state_q, state_d;
  width_t us_cnt_q, us_cnt_d, us_cnt_inc;
  logic   timeout_hit, capture;

  // Captured value includes a tick landing on the falling-edge cycle itself.
  assign us_cnt_inc  = (us_tick && us_cnt_q != TIMEOUT) ? us_cnt_q + 16'd1 : us_cnt_q;
  assign timeout_hit = us_tick && (us_cnt_q == TIMEOUT - 16'd1);

  always_comb begin
    state_d  = state_q;
    us_cnt_d = us_cnt_inc;
    capture  = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (!pin_level) begin
          state_d  = WAIT_RISE;
          us_cnt_d = '0;
        end
      end
      WAIT_RISE: begin
        if (pin_rise) begin
          state_d  = HIGH;
          us_cnt_d = '0;
        end
      end
      HIGH: begin
        if (pin_fall) begin
          capture  = 1'b1;
          state_d  = WAIT_RISE;
          us_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d  = WAIT_LOW;
          us_cnt_d = '0;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOW;
      us_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
    end
  end

  width_t      cap_q, w2_q;
  logic        cap_vld_q, s2_vld_q, in_range_q;
  logic [31:0] prod_q, prod_d;
  logic [POS_W-1:0] pos_scaled;

  assign prod_d     = 32'((48'(cap_q - MIN_W) * 48'(SCALE)) >> 16);
  assign pos_scaled = (prod_q > POS_MAX) ? POS_MAX[POS_W-1:0] : prod_q[POS_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q       <= '0;
      cap_vld_q   <= 1'b0;
      w2_q        <= '0;
      s2_vld_q    <= 1'b0;
      in_range_q  <= 1'b0;
      prod_q      <= '0;
      width_us    <= '0;
      pos         <= '0;
      pos_valid   <= 1'b0;
      err_range   <= 1'b0;
      signal_lost <= 1'b1;
      led_verde   <= 1'b0;
    end else begin
      cap_vld_q <= capture;
      if (capture) cap_q <= us_cnt_inc;

      s2_vld_q <= cap_vld_q;
      if (cap_vld_q) begin
        w2_q       <= cap_q;
        in_range_q <= (cap_q >= MIN_W) && (cap_q <= MAX_W);
        prod_q     <= prod_d;
      end

      pos_valid <= s2_vld_q & in_range_q;
      err_range <= s2_vld_q & ~in_range_q;
      if (s2_vld_q) width_us <= w2_q;
      if (s2_vld_q && in_range_q) pos <= pos_scaled;

      if (timeout_hit) begin
        signal_lost <= 1'b1;
        led_verde   <= 1'b0;
      end else if (s2_vld_q && in_range_q) begin
        signal_lost <= 1'b0;
        led_verde   <= 1'b1;
      end
    end
  end

  assign led_verm = signal_lost;

endmodule

`default_nettype wire
